// File: rtl/mem_responder_if.sv
// Request/response bundle between a core memory port and its responder.
// valid/ready: a request transfers on a rising edge where req_valid and req_ready are both 1;
// the requester holds its request stable while req_ready is 0. Responses have no backpressure.
interface mem_responder_if;
  logic [31:0] mem_in_req_addr;
  logic [31:0] mem_in_req_data;
  logic [1:0]  mem_in_req_fcn;
  logic [2:0]  mem_in_req_typ;
  logic        mem_in_req_valid;
  logic        mem_out_req_ready;
  logic        mem_out_res_valid;
  logic [31:0] mem_out_res_data;
  logic [1:0]  dbg_state;

  modport master (
    output mem_in_req_addr, mem_in_req_data, mem_in_req_fcn, mem_in_req_typ, mem_in_req_valid,
    input  mem_out_req_ready, mem_out_res_valid, mem_out_res_data, dbg_state
  );

  modport slave (
    input  mem_in_req_addr, mem_in_req_data, mem_in_req_fcn, mem_in_req_typ, mem_in_req_valid,
    output mem_out_req_ready, mem_out_res_valid, mem_out_res_data, dbg_state
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory answering core load/store requests after a fixed latency,
// with an optional busy throttle that drops req_ready for a few cycles after each acceptance.
module mem_responder #(
  parameter int    ADDR_BITS   = 14,
  parameter int    LATENCY     = 1,
  parameter int    BUSY_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave mem
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  localparam logic [3:0] BUSY_LOAD = 4'(BUSY_CYCLES);

  state_t      state, state_next;
  logic [3:0]  busy_cnt, busy_cnt_next;
  logic        req_ready;
  logic        accept;

  logic [31:0] mem_array [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] idx;
  logic [31:0] word;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic        is_b, is_h, is_signed;

  logic        vld_pipe [LATENCY];
  logic [31:0] dat_pipe [LATENCY];

  logic        unused_addr_bits;
  assign unused_addr_bits = ^mem.mem_in_req_addr[31:ADDR_BITS+2];

  assign req_ready = (state == ST_IDLE);
  assign accept    = reset && mem.mem_in_req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_RESET;
      busy_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      busy_cnt <= busy_cnt_next;
    end
  end

  // ST_RESET keeps req_ready low for the cycle following a reset edge.
  always_comb begin
    state_next    = state;
    busy_cnt_next = busy_cnt;
    case (state)
      ST_RESET: state_next = ST_IDLE;
      ST_IDLE: begin
        if (accept && (BUSY_CYCLES > 0)) begin
          busy_cnt_next = BUSY_LOAD;
          state_next    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy_cnt_next = busy_cnt - 4'd1;
        if (busy_cnt <= 4'd1) state_next = ST_IDLE;
      end
      default: state_next = ST_RESET;
    endcase
  end

  assign idx  = mem.mem_in_req_addr[ADDR_BITS+1:2];
  assign word = mem_array[idx];

  always_comb begin
    is_b      = (mem.mem_in_req_typ == 3'd1) || (mem.mem_in_req_typ == 3'd5);
    is_h      = (mem.mem_in_req_typ == 3'd2) || (mem.mem_in_req_typ == 3'd6);
    is_signed = (mem.mem_in_req_typ == 3'd1) || (mem.mem_in_req_typ == 3'd2);
    wmask     = 4'b1111;
    wdata     = mem.mem_in_req_data;
    if (is_b) begin
      wmask = 4'b0001 << mem.mem_in_req_addr[1:0];
      wdata = {4{mem.mem_in_req_data[7:0]}};
    end else if (is_h) begin
      wmask = mem.mem_in_req_addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{mem.mem_in_req_data[15:0]}};
    end
  end

  always_comb begin
    lane_b    = 8'(word >> {mem.mem_in_req_addr[1:0], 3'b000});
    lane_h    = mem.mem_in_req_addr[1] ? word[31:16] : word[15:0];
    load_data = word;
    if (mem.mem_in_req_fcn != 2'd0) begin
      load_data = 32'd0;
    end else if (is_b) begin
      load_data = {{24{is_signed & lane_b[7]}}, lane_b};
    end else if (is_h) begin
      load_data = {{16{is_signed & lane_h[15]}}, lane_h};
    end
  end

  // Memory has no reset so contents survive reset pulses.
  always_ff @(posedge clk) begin
    if (accept && (mem.mem_in_req_fcn == 2'd1)) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem_array[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_pipe[i] <= 1'b0;
        dat_pipe[i] <= 32'd0;
      end
    end else begin
      vld_pipe[0] <= accept;
      dat_pipe[0] <= accept ? load_data : 32'd0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign mem.mem_out_req_ready = req_ready;
  assign mem.mem_out_res_valid = vld_pipe[LATENCY-1];
  assign mem.mem_out_res_data  = dat_pipe[LATENCY-1];
  assign mem.dbg_state         = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances with different parameters share one
// request bus; sel chooses which instance sees req_valid and whose outputs are observed.
module tb_mem_responder;

  typedef struct {
    logic [1:0]  fcn;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_fcn;
  logic [2:0]  req_typ;
  logic        req_valid;
  int          sel;

  logic        rdy_v [4];
  logic        vld_v [4];
  logic [31:0] dat_v [4];
  logic        cur_ready;
  logic        cur_valid;
  logic [31:0] cur_data;

  int          checks = 0;
  int          failures = 0;
  vec_t        vq[$];
  logic [31:0] exp_q[$];
  logic        obs_v[$];
  logic [31:0] obs_d[$];

  always #5 clk = ~clk;

  mem_responder_if if_x[4] ();

  for (genvar g = 0; g < 4; g++) begin : g_bus
    assign if_x[g].mem_in_req_addr  = req_addr;
    assign if_x[g].mem_in_req_data  = req_data;
    assign if_x[g].mem_in_req_fcn   = req_fcn;
    assign if_x[g].mem_in_req_typ   = req_typ;
    assign if_x[g].mem_in_req_valid = req_valid && (sel == g);
    assign rdy_v[g] = if_x[g].mem_out_req_ready;
    assign vld_v[g] = if_x[g].mem_out_res_valid;
    assign dat_v[g] = if_x[g].mem_out_res_data;
  end

  always_comb begin
    cur_ready = rdy_v[sel];
    cur_valid = vld_v[sel];
    cur_data  = dat_v[sel];
  end

  mem_responder #(.ADDR_BITS(14), .LATENCY(1), .BUSY_CYCLES(0)) u_a (.clk(clk), .reset(reset), .mem(if_x[0]));
  mem_responder #(.ADDR_BITS(14), .LATENCY(1), .BUSY_CYCLES(3)) u_b (.clk(clk), .reset(reset), .mem(if_x[1]));
  mem_responder #(.ADDR_BITS(14), .LATENCY(3), .BUSY_CYCLES(0)) u_c (.clk(clk), .reset(reset), .mem(if_x[2]));
  mem_responder #(.ADDR_BITS(4),  .LATENCY(1), .BUSY_CYCLES(0)) u_d (.clk(clk), .reset(reset), .mem(if_x[3]));

  // ---------------- driver tasks ----------------
  task automatic add_vec(input logic [1:0] fcn, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] data, input logic [31:0] expv);
    vec_t v;
    v.fcn = fcn; v.typ = typ; v.addr = addr; v.data = data;
    vq.push_back(v);
    exp_q.push_back(expv);
  endtask

  task automatic set_vec(input vec_t v);
    req_fcn   = v.fcn;
    req_typ   = v.typ;
    req_addr  = v.addr;
    req_data  = v.data;
    req_valid = 1'b1;
  endtask

  // Drives vq back-to-back, one per cycle; obs[j] is sampled in the cycle after the j-th edge.
  task automatic run_vectors(input int ncyc);
    obs_v.delete();
    obs_d.delete();
    @(posedge clk); #1;
    set_vec(vq[0]);
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk); #1;
      if (j + 1 < vq.size()) set_vec(vq[j+1]);
      else req_valid = 1'b0;
      @(negedge clk);
      obs_v.push_back(cur_valid);
      obs_d.push_back(cur_data);
    end
    vq.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_fcn = 2'd0; req_typ = 3'd3;
    req_addr = 32'd0; req_data = 32'd0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      checks++;
      if (cur_ready !== 1'b0 || cur_valid !== 1'b0 || cur_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_outputs dut=%0d: got ready=%b valid=%b data=%h, expected 0/0/0", s, cur_ready, cur_valid, cur_data);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      checks++;
      if (cur_ready !== 1'b1 || cur_valid !== 1'b0) begin
        failures++;
        $display("FAIL after_reset dut=%0d: got ready=%b valid=%b, expected ready=1 valid=0", s, cur_ready, cur_valid);
      end
    end
    sel = 0;
  endtask

  task automatic test_write_read();
    sel = 0;
    add_vec(2'd1, 3'd3, 32'h10, 32'hDEADBEEF, 32'h0);
    add_vec(2'd0, 3'd3, 32'h10, 32'h0, 32'hDEADBEEF);
    run_vectors(3);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs_v[i] !== 1'b1 || obs_d[i] !== e) begin
        failures++;
        $display("FAIL write_read[%0d]: got valid=%b data=%h, expected valid=1 data=%h", i, obs_v[i], obs_d[i], e);
      end
    end
    checks++;
    if (obs_v[2] !== 1'b0) begin
      failures++;
      $display("FAIL write_read_tail: got valid=%b, expected 0", obs_v[2]);
    end
  endtask

  task automatic test_lanes();
    sel = 0;
    add_vec(2'd1, 3'd3, 32'h20, 32'h11223344, 32'h0);
    add_vec(2'd1, 3'd1, 32'h22, 32'h123456AB, 32'h0);
    add_vec(2'd0, 3'd3, 32'h20, 32'h0, 32'h11AB3344);
    add_vec(2'd0, 3'd1, 32'h22, 32'h0, 32'hFFFFFFAB);
    add_vec(2'd0, 3'd5, 32'h22, 32'h0, 32'h000000AB);
    add_vec(2'd0, 3'd2, 32'h22, 32'h0, 32'h000011AB);
    add_vec(2'd1, 3'd3, 32'h30, 32'h0, 32'h0);
    add_vec(2'd1, 3'd2, 32'h32, 32'hFFFF8001, 32'h0);
    add_vec(2'd0, 3'd3, 32'h30, 32'h0, 32'h80010000);
    add_vec(2'd0, 3'd6, 32'h32, 32'h0, 32'h00008001);
    add_vec(2'd0, 3'd2, 32'h32, 32'h0, 32'hFFFF8001);
    add_vec(2'd0, 3'd7, 32'h31, 32'h0, 32'h80010000);
    add_vec(2'd0, 3'd1, 32'h23, 32'h0, 32'h00000011);
    run_vectors(14);
    for (int i = 0; i < 13; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs_v[i] !== 1'b1 || obs_d[i] !== e) begin
        failures++;
        $display("FAIL lanes[%0d]: got valid=%b data=%h, expected valid=1 data=%h", i, obs_v[i], obs_d[i], e);
      end
    end
    checks++;
    if (obs_v[13] !== 1'b0) begin
      failures++;
      $display("FAIL lanes_tail: got valid=%b, expected 0", obs_v[13]);
    end
  endtask

  task automatic test_throttle();
    int acc;
    int resp;
    acc = 0; resp = 0;
    sel = 1;
    @(posedge clk); #1;
    req_fcn = 2'd1; req_typ = 3'd3; req_addr = 32'h4; req_data = 32'h5A; req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (cur_ready !== ((i % 4) == 0) || cur_valid !== ((i % 4) == 1)) begin
        failures++;
        $display("FAIL throttle[%0d]: got ready=%b valid=%b, expected ready=%b valid=%b",
                 i, cur_ready, cur_valid, (i % 4) == 0, (i % 4) == 1);
      end
      if (cur_valid === 1'b1) begin
        resp++;
        checks++;
        if (cur_data !== 32'd0) begin
          failures++;
          $display("FAIL throttle_data[%0d]: got %h, expected 00000000", i, cur_data);
        end
      end
      if (cur_ready === 1'b1) acc++;
    end
    req_valid = 1'b0;
    checks++;
    if (acc !== 3 || resp !== 3) begin
      failures++;
      $display("FAIL throttle_count: got accepts=%0d responses=%0d, expected 3/3", acc, resp);
    end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_latency3();
    sel = 2;
    add_vec(2'd1, 3'd3, 32'h0, 32'd1, 32'h0);
    add_vec(2'd1, 3'd3, 32'h4, 32'd2, 32'h0);
    add_vec(2'd1, 3'd3, 32'h8, 32'd3, 32'h0);
    add_vec(2'd0, 3'd3, 32'h0, 32'h0, 32'd1);
    add_vec(2'd0, 3'd3, 32'h4, 32'h0, 32'd2);
    add_vec(2'd0, 3'd3, 32'h8, 32'h0, 32'd3);
    run_vectors(9);
    checks++;
    if (obs_v[0] !== 1'b0 || obs_v[1] !== 1'b0) begin
      failures++;
      $display("FAIL lat3_early: got valid=%b,%b, expected 0,0", obs_v[0], obs_v[1]);
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs_v[i+2] !== 1'b1 || obs_d[i+2] !== e) begin
        failures++;
        $display("FAIL lat3[%0d]: got valid=%b data=%h, expected valid=1 data=%h", i, obs_v[i+2], obs_d[i+2], e);
      end
    end
    checks++;
    if (obs_v[8] !== 1'b0) begin
      failures++;
      $display("FAIL lat3_tail: got valid=%b, expected 0", obs_v[8]);
    end
  endtask

  task automatic test_wrap_noop();
    sel = 3;
    add_vec(2'd1, 3'd3, 32'h40, 32'h55, 32'h0);
    add_vec(2'd0, 3'd3, 32'h00, 32'h0, 32'h55);
    add_vec(2'd2, 3'd3, 32'h00, 32'hFFFFFFFF, 32'h0);
    add_vec(2'd3, 3'd1, 32'h01, 32'hFFFFFFFF, 32'h0);
    add_vec(2'd0, 3'd3, 32'h80, 32'h0, 32'h55);
    run_vectors(6);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs_v[i] !== 1'b1 || obs_d[i] !== e) begin
        failures++;
        $display("FAIL wrap_noop[%0d]: got valid=%b data=%h, expected valid=1 data=%h", i, obs_v[i], obs_d[i], e);
      end
    end
    checks++;
    if (obs_v[5] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_noop_tail: got valid=%b, expected 0", obs_v[5]);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    sel = 2;
    @(posedge clk); #1;
    req_fcn = 2'd1; req_typ = 3'd3; req_addr = 32'h44; req_data = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_fcn = 2'd0; req_data = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cur_ready !== 1'b0 || cur_valid !== 1'b0) begin
      failures++;
      $display("FAIL midflight_reset_cycle: got ready=%b valid=%b, expected 0/0", cur_ready, cur_valid);
    end
    @(negedge clk);
    checks++;
    if (cur_ready !== 1'b1) begin
      failures++;
      $display("FAIL midflight_ready: got ready=%b, expected 1", cur_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (cur_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midflight_discard: got %0d responses after reset, expected 0", seen);
    end
    add_vec(2'd0, 3'd3, 32'h44, 32'h0, 32'hCAFEF00D);
    run_vectors(4);
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs_v[0] !== 1'b0 || obs_v[1] !== 1'b0 || obs_v[2] !== 1'b1 || obs_d[2] !== e || obs_v[3] !== 1'b0) begin
        failures++;
        $display("FAIL midflight_readback: got valid=%b%b%b%b data=%h, expected valid=0010 data=%h",
                 obs_v[0], obs_v[1], obs_v[2], obs_v[3], obs_d[2], e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_lanes();
    test_throttle();
    test_latency3();
    test_wrap_noop();
    test_reset_midflight();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover expectations, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
